vrf_operand_requester: RTL and testbench



---
 rtl/vrf_operand_requester.sv | 148 ++++++++++++++
 tb/tb_vrf_operand_requester.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_operand_requester.sv
// VRF operand requester: streams command reads across banks under
// operand-queue credits, while writes always win their bank.
package vrf_operand_requester_pkg;
   typedef enum logic [2:0] {
      ALU_A, ALU_B, ALU_C, MFPU_A,
      MFPU_B, MFPU_C, ST_A, MASK_M
   } opqueue_e;
endpackage

module vrf_operand_requester
   import vrf_operand_requester_pkg::*;
#(
   parameter int NrBanks    = 8,
   parameter int VAddrWidth = 16,
   parameter int LenWidth   = 10,
   parameter int QueueDepth = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 cmd_valid_i,
   output logic                                 cmd_ready_o,
   input  logic [VAddrWidth-1:0]                cmd_addr_i,
   input  logic [LenWidth-1:0]                  cmd_len_i,
   input  opqueue_e                             cmd_opqueue_i,
   input  logic                                 wr_valid_i,
   output logic                                 wr_ready_o,
   input  logic [VAddrWidth-1:0]                wr_addr_i,
   input  logic [63:0]                          wr_data_i,
   input  logic [7:0]                           wr_be_i,
   input  logic                                 credit_i,
   output logic [NrBanks-1:0]                   req_o,
   output logic [NrBanks-1:0]                   wen_o,
   output logic [NrBanks-1:0][VAddrWidth-1:0]   addr_o,
   output opqueue_e [NrBanks-1:0]               tgt_opqueue_o,
   output logic [NrBanks-1:0][63:0]             wdata_o,
   output logic [NrBanks-1:0][7:0]              be_o,
   output logic                                 done_o
);

   localparam int BankW = $clog2(NrBanks);
   localparam int CredW = $clog2(QueueDepth + 1);
   localparam logic [CredW-1:0] CredMax = CredW'(QueueDepth);

   typedef enum logic {IDLE, READ} state_e;

   state_e                state_q, state_d;
   logic [VAddrWidth-1:0] addr_q, addr_d;
   logic [LenWidth-1:0]   rem_q, rem_d;
   opqueue_e              op_q, op_d;
   logic [CredW-1:0]      cred_q, cred_d;
   logic                  done_q, done_d;
   logic [BankW-1:0]      rd_bank, wr_bank;
   logic                  rd_issue;

   assign rd_bank    = addr_q[BankW-1:0];
   assign wr_bank    = wr_addr_i[BankW-1:0];
   assign wr_ready_o = 1'b1;
   assign done_o     = done_q;

   // A write to the same bank takes the port; the read retries next cycle
   assign rd_issue = (state_q == READ) && (cred_q != '0) &&
                     !(wr_valid_i && (wr_bank == rd_bank));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      op_d        = op_q;
      done_d      = 1'b0;
      cmd_ready_o = (state_q == IDLE);
      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               if (cmd_len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = READ;
                  addr_d  = cmd_addr_i;
                  rem_d   = cmd_len_i;
                  op_d    = cmd_opqueue_i;
               end
            end
         end
         READ: begin
            if (rd_issue) begin
               addr_d = addr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               if (rem_q == LenWidth'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      cred_d = cred_q;
      if (rd_issue && !credit_i) begin
         cred_d = cred_q - 1'b1;
      end else if (!rd_issue && credit_i && (cred_q != CredMax)) begin
         cred_d = cred_q + 1'b1;
      end
   end

   always_comb begin
      req_o   = '0;
      wen_o   = '0;
      addr_o  = '0;
      wdata_o = '0;
      be_o    = '0;
      for (int b = 0; b < NrBanks; b++) begin
         tgt_opqueue_o[b] = ALU_A;
         if (wr_valid_i && (wr_bank == BankW'(b))) begin
            req_o[b]   = 1'b1;
            wen_o[b]   = 1'b1;
            addr_o[b]  = wr_addr_i;
            wdata_o[b] = wr_data_i;
            be_o[b]    = wr_be_i;
         end
         if (rd_issue && (rd_bank == BankW'(b))) begin
            req_o[b]         = 1'b1;
            addr_o[b]        = addr_q;
            tgt_opqueue_o[b] = op_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         op_q    <= ALU_A;
         cred_q  <= CredMax;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         cred_q  <= cred_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_vrf_operand_requester.sv
// Randomized bench for vrf_operand_requester with a cycle-level
// reference model and directed scenarios pinning the model.
module tb_vrf_operand_requester;
   import vrf_operand_requester_pkg::*;

   localparam int NrBanks    = 8;
   localparam int VAddrWidth = 16;
   localparam int LenWidth   = 10;
   localparam int QueueDepth = 4;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic cmd_valid_i, cmd_ready_o;
   logic [VAddrWidth-1:0] cmd_addr_i;
   logic [LenWidth-1:0] cmd_len_i;
   opqueue_e cmd_opqueue_i;
   logic wr_valid_i, wr_ready_o;
   logic [VAddrWidth-1:0] wr_addr_i;
   logic [63:0] wr_data_i;
   logic [7:0] wr_be_i;
   logic credit_i;
   logic [NrBanks-1:0] req_o, wen_o;
   logic [NrBanks-1:0][VAddrWidth-1:0] addr_o;
   opqueue_e [NrBanks-1:0] tgt_opqueue_o;
   logic [NrBanks-1:0][63:0] wdata_o;
   logic [NrBanks-1:0][7:0] be_o;
   logic done_o;

   vrf_operand_requester #(
      .NrBanks(NrBanks), .VAddrWidth(VAddrWidth),
      .LenWidth(LenWidth), .QueueDepth(QueueDepth)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
      .cmd_opqueue_i(cmd_opqueue_i),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
      .credit_i(credit_i),
      .req_o(req_o), .wen_o(wen_o), .addr_o(addr_o),
      .tgt_opqueue_o(tgt_opqueue_o),
      .wdata_o(wdata_o), .be_o(be_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: abstract command progress
   bit       busy;
   int       m_addr, m_rem, m_cred;
   bit       m_done;
   opqueue_e m_op;

   // Observations from the most recent step
   logic [NrBanks-1:0] o_req, o_wen;
   logic [NrBanks-1:0][VAddrWidth-1:0] o_addr;
   logic o_done, o_rdy;

   task automatic chk(string nm, logic [1023:0] act, logic [1023:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      busy = 0; m_addr = 0; m_rem = 0;
      m_cred = QueueDepth; m_done = 0; m_op = ALU_A;
   endtask

   task automatic step(input bit cv, input int ca, input int cl,
                       input opqueue_e co, input bit wv, input int wa,
                       input logic [63:0] wd, input logic [7:0] wbe,
                       input bit cr);
      logic [NrBanks-1:0] e_req, e_wen;
      logic [NrBanks-1:0][VAddrWidth-1:0] e_addr;
      logic [NrBanks-1:0][63:0] e_data;
      logic [NrBanks-1:0][7:0] e_be;
      opqueue_e [NrBanks-1:0] e_tgt;
      logic [NrBanks*3-1:0] a_tgt, x_tgt;
      bit rd;
      @(negedge clk_i);
      cmd_valid_i = cv;
      cmd_addr_i = VAddrWidth'(ca);
      cmd_len_i = LenWidth'(cl);
      cmd_opqueue_i = co;
      wr_valid_i = wv;
      wr_addr_i = VAddrWidth'(wa);
      wr_data_i = wd;
      wr_be_i = wbe;
      credit_i = cr;
      #1;
      e_req = '0; e_wen = '0; e_addr = '0; e_data = '0; e_be = '0;
      for (int b = 0; b < NrBanks; b++) e_tgt[b] = ALU_A;
      rd = busy && (m_cred > 0) &&
           !(wv && ((wa % NrBanks) == (m_addr % NrBanks)));
      if (wv) begin
         e_req[wa % NrBanks] = 1'b1;
         e_wen[wa % NrBanks] = 1'b1;
         e_addr[wa % NrBanks] = VAddrWidth'(wa);
         e_data[wa % NrBanks] = wd;
         e_be[wa % NrBanks] = wbe;
      end
      if (rd) begin
         e_req[m_addr % NrBanks] = 1'b1;
         e_addr[m_addr % NrBanks] = VAddrWidth'(m_addr);
         e_tgt[m_addr % NrBanks] = m_op;
      end
      a_tgt = tgt_opqueue_o;
      x_tgt = e_tgt;
      chk("cmd_ready", 1024'(cmd_ready_o), 1024'(!busy));
      chk("wr_ready", 1024'(wr_ready_o), 1024'(1));
      chk("done", 1024'(done_o), 1024'(m_done));
      chk("req", 1024'(req_o), 1024'(e_req));
      chk("wen", 1024'(wen_o), 1024'(e_wen));
      chk("addr", 1024'(addr_o), 1024'(e_addr));
      chk("tgt", 1024'(a_tgt), 1024'(x_tgt));
      chk("wdata", 1024'(wdata_o), 1024'(e_data));
      chk("be", 1024'(be_o), 1024'(e_be));
      o_req = req_o; o_wen = wen_o; o_addr = addr_o;
      o_done = done_o; o_rdy = cmd_ready_o;
      @(posedge clk_i);
      m_done = 0;
      if (!busy && cv) begin
         if (cl == 0) m_done = 1;
         else begin
            busy = 1; m_addr = ca; m_rem = cl; m_op = co;
         end
      end else if (rd) begin
         m_addr = (m_addr + 1) % (2 ** VAddrWidth);
         m_rem = m_rem - 1;
         if (m_rem == 0) begin
            busy = 0; m_done = 1;
         end
      end
      m_cred = m_cred - int'(rd) + int'(cr);
      if (m_cred > QueueDepth) m_cred = QueueDepth;
   endtask

   task automatic idle(input bit cr);
      step(0, 0, 0, ALU_A, 0, 0, 64'h0, 8'h0, cr);
   endtask

   task automatic cmd(input int a, input int l, input opqueue_e o);
      step(1, a, l, o, 0, 0, 64'h0, 8'h0, 0);
   endtask

   task automatic refill();
      for (int i = 0; i < QueueDepth + 1; i++) idle(1);
      chk("credits_refilled", 1024'(m_cred), 1024'(QueueDepth));
   endtask

   initial begin
      int banks[4];
      rst_ni = 1'b0;
      cmd_valid_i = 0; cmd_addr_i = '0; cmd_len_i = '0;
      cmd_opqueue_i = ALU_A; wr_valid_i = 0; wr_addr_i = '0;
      wr_data_i = '0; wr_be_i = '0; credit_i = 0;
      model_reset();
      repeat (2) @(negedge clk_i);
      chk("rst_ready", 1024'(cmd_ready_o), 1024'(1));
      chk("rst_req", 1024'(req_o), 1024'(0));
      chk("rst_done", 1024'(done_o), 1024'(0));
      rst_ni = 1'b1;

      // Stream across banks 6,7,0,1
      banks = '{6, 7, 0, 1};
      cmd(6, 4, MFPU_B);
      for (int i = 0; i < 4; i++) begin
         idle(0);
         chk("s038_req", 1024'(o_req), 1024'(8'h01 << banks[i]));
         chk("s038_addr", 1024'(o_addr[banks[i]]), 1024'(6 + i));
      end
      idle(0);
      chk("s038_done", 1024'(o_done), 1024'(1));
      chk("s038_cred", 1024'(m_cred), 1024'(0));
      refill();

      // Credit starvation
      cmd(32'h20, 6, ALU_B);
      for (int i = 0; i < 4; i++) begin
         idle(0);
         chk("s039_issue", 1024'(o_req != 0), 1024'(1));
      end
      idle(0); idle(0);
      chk("s039_stall", 1024'(o_req), 1024'(0));
      idle(1);
      chk("s039_credcyc", 1024'(o_req), 1024'(0));
      idle(1);
      chk("s039_r5", 1024'(o_req), 1024'(8'h10));
      idle(0);
      chk("s039_r6", 1024'(o_req), 1024'(8'h20));
      idle(0);
      chk("s039_done", 1024'(o_done), 1024'(1));
      refill();

      // Write/read bank conflict
      cmd(32'h10, 2, ST_A);
      step(0, 0, 0, ALU_A, 1, 32'h8, 64'hDEAD_BEEF_0123_4567, 8'hF0, 0);
      chk("s040_req_conf", 1024'(o_req), 1024'(8'h01));
      chk("s040_wen_conf", 1024'(o_wen), 1024'(8'h01));
      step(0, 0, 0, ALU_A, 1, 32'h9, 64'h1, 8'h01, 0);
      chk("s040_req_both", 1024'(o_req), 1024'(8'h03));
      chk("s040_wen_both", 1024'(o_wen), 1024'(8'h02));
      chk("s040_addr_rd", 1024'(o_addr[0]), 1024'(16'h0010));
      idle(0);
      chk("s040_req_last", 1024'(o_req), 1024'(8'h02));
      idle(0);
      refill();

      // Address wrap
      cmd(32'hFFFF, 2, MASK_M);
      idle(0);
      chk("s041_req0", 1024'(o_req), 1024'(8'h80));
      chk("s041_addr0", 1024'(o_addr[7]), 1024'(16'hFFFF));
      idle(0);
      chk("s041_req1", 1024'(o_req), 1024'(8'h01));
      chk("s041_addr1", 1024'(o_addr[0]), 1024'(0));
      idle(0);
      refill();

      // Zero-length command
      cmd(32'h33, 0, ALU_C);
      idle(0);
      chk("s042_done", 1024'(o_done), 1024'(1));
      chk("s042_req", 1024'(o_req), 1024'(0));
      chk("s042_ready", 1024'(o_rdy), 1024'(1));

      // Reset in the middle of a command
      cmd(32'h40, 5, ALU_A);
      idle(0); idle(0);
      @(negedge clk_i);
      cmd_valid_i = 0; wr_valid_i = 0; credit_i = 0;
      rst_ni = 1'b0;
      #1;
      chk("s043_req", 1024'(req_o), 1024'(0));
      chk("s043_ready", 1024'(cmd_ready_o), 1024'(1));
      chk("s043_done", 1024'(done_o), 1024'(0));
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle(0); idle(0);
      cmd(32'h5, 1, MFPU_A);
      idle(0);
      chk("s043_newcmd", 1024'(o_req), 1024'(8'h20));
      idle(0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) == 0,
              int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 7)),
              opqueue_e'($urandom_range(0, 7)),
              $urandom_range(0, 2) == 0,
              int'($urandom_range(0, 65535)),
              {$urandom, $urandom},
              8'($urandom),
              $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
